// File: rtl/bit_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : bit_serializer                                                      |
// | Brief  : Parallel-to-serial front end with a one-word pending buffer for     |
// |          gapless streaming into the sequence detector.                       |
// |          Optional macro BIT_SER_LSB_FIRST_EN selects LSB-first transmission. |
// | Rev    : 1.0  initial release                                                |
// +-----------------------------------------------------------------------------+
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH-1:0]   r_pend;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_pend_full;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_sh_shifted;
  logic               w_head_bit;

  assign w_accept = data_valid && !r_pend_full;
  assign w_last   = (r_cnt == c_LAST);

`ifdef BIT_SER_LSB_FIRST_EN
  assign w_sh_shifted = {1'b0, r_sh[WIDTH-1:1]};
  assign w_head_bit   = r_sh[0];
`else
  assign w_sh_shifted = {r_sh[WIDTH-2:0], 1'b0};
  assign w_head_bit   = r_sh[WIDTH-1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_pend      <= '0;
      r_cnt       <= '0;
      r_pend_full <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sh    <= data_in;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!w_last) begin
            r_sh  <= w_sh_shifted;
            r_cnt <= r_cnt + 1'b1;
            if (w_accept) begin
              r_pend      <= data_in;
              r_pend_full <= 1'b1;
            end
          end else if (r_pend_full) begin
            // Pending word takes priority; data_ready is low so nothing new arrives.
            r_sh        <= r_pend;
            r_pend_full <= 1'b0;
            r_cnt       <= '0;
          end else if (w_accept) begin
            r_sh  <= data_in;
            r_cnt <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of flops, so they clear with the async reset.
  assign bit_valid  = (r_state == S_SHIFT);
  assign bit_out    = bit_valid && w_head_bit;
  assign word_done  = bit_valid && w_last;
  assign data_ready = !r_pend_full;
  assign busy       = bit_valid || r_pend_full;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : tb_bit_serializer                                                   |
// | Brief  : Randomized self-checking bench against a bit-queue reference model. |
// | Rev    : 1.0  initial release                                                |
// +-----------------------------------------------------------------------------+
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         bit_out;
  logic         bit_valid;
  logic         word_done;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: every bit still to appear on bit_out, with a last-of-word flag.
  bit mq[$];
  bit ml[$];
  bit coll[$];
  bit in_reset;
  bit last_refused;
  logic [W-1:0] last_data;

  bit_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h required %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] tx_order(input logic [W-1:0] d);
    logic [W-1:0] r;
`ifdef BIT_SER_LSB_FIRST_EN
    for (int i = 0; i < W; i++) r[W-1-i] = d[i];
`else
    r = d;
`endif
    return r;
  endfunction

  function automatic logic [63:0] pack_coll();
    logic [63:0] v = '0;
    foreach (coll[i]) v = {v[62:0], coll[i]};
    return v;
  endfunction

  task automatic compare_outputs();
    int n = mq.size();
    check("bit_out",    bit_out,    (n > 0) ? mq[0] : 1'b0);
    check("bit_valid",  bit_valid,  n > 0);
    check("word_done",  word_done,  (n > 0) ? ml[0] : 1'b0);
    check("data_ready", data_ready, n <= W);
    check("busy",       busy,       n > 0);
    if (bit_valid) coll.push_back(bit_out);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at negedge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    logic [W-1:0] tx;
    bit acc;
    data_valid = v;
    data_in    = d;
    acc = !in_reset && v && (mq.size() <= W);
    last_refused = v && !acc;
    last_data    = d;
    @(posedge clk);
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      void'(ml.pop_front());
    end
    if (acc) begin
      tx = tx_order(d);
      for (int i = W - 1; i >= 0; i--) begin
        mq.push_back(tx[i]);
        ml.push_back(i == 0);
      end
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic async_reset_now();
    #3 reset = 1'b0;
    in_reset = 1'b1;
    mq.delete();
    ml.delete();
    #1;
    compare_outputs();
    @(negedge clk);
    reset = 1'b1;
    in_reset = 1'b0;
    last_refused = 1'b0;
  endtask

  initial begin
    logic [W-1:0] words [3];
    logic [W-1:0] w09;
    int idx;
    int nr;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hFF;
    w09 = 8'h09;

    reset = 1'b0;
    in_reset = 1'b1;
    data_valid = 1'b0;
    data_in = '0;
    last_refused = 1'b0;

    // 1. Reset held with random inputs, then quiet after release.
    @(negedge clk);
    for (int i = 0; i < 6; i++) cycle(1'($urandom), W'($urandom));
    reset = 1'b1;
    in_reset = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0);

    // 2. Single word 8'h09.
    cycle(1'b1, w09);
    for (int i = 1; i <= W; i++) begin
`ifdef BIT_SER_LSB_FIRST_EN
      check("single_bit", bit_out, w09[i-1]);
`else
      check("single_bit", bit_out, w09[W-i]);
`endif
      check("single_done", word_done, i == W);
      cycle(1'b0, '0);
    end
    check("single_idle_valid", bit_valid, 1'b0);
    check("single_idle_bit", bit_out, 1'b0);

    // 3/4. Back-to-back with data_valid held; third word sees backpressure.
    coll.delete();
    idx = 0;
    nr = 0;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      bit a;
      a = (mq.size() <= W);
      if (idx == 2 && !a) nr++;
      cycle(1'b1, words[idx]);
      if (a) idx++;
    end
    check("b2b_accepts", idx, 3);
    check("bp_ready_low_cycles", nr, 7);
    for (int i = 0; i < 3 * W; i++) cycle(1'b0, '0);
    check("b2b_bit_count", coll.size(), 3 * W);
    check("b2b_stream", pack_coll(), {40'h0, tx_order(words[0]), tx_order(words[1]), tx_order(words[2])});

    // 5. Async reset in the middle of 8'h09, then a clean restart.
    cycle(1'b1, w09);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0);
    check("pre_reset_valid", bit_valid, 1'b1);
    #3 reset = 1'b0;
    in_reset = 1'b1;
    #1;
    check("rst_bit_valid", bit_valid, 1'b0);
    check("rst_bit_out", bit_out, 1'b0);
    check("rst_data_ready", data_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    mq.delete();
    ml.delete();
    @(negedge clk);
    cycle(1'b1, 8'h77);
    reset = 1'b1;
    in_reset = 1'b0;
    coll.delete();
    cycle(1'b1, 8'hC3);
    for (int i = 0; i < W + 2; i++) cycle(1'b0, '0);
    check("restart_stream", pack_coll(), {56'h0, tx_order(8'hC3)});

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset_now();
      end else if (last_refused && $urandom_range(0, 3) != 0) begin
        cycle(1'b1, last_data);
      end else begin
        cycle($urandom_range(0, 9) < 6, W'($urandom));
      end
    end
    for (int i = 0; i < 2 * W + 2; i++) cycle(1'b0, '0);
    check("final_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
